dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, DM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: req  input  2  per-port request; port 0 = CPU MEM stage, port 1 = DMA.
REQ-006 SHALL have ports: we  input  2  per-port write (1) / read (0).
REQ-007 SHALL have ports: addr0, addr1  input  32 each  byte address.
REQ-008 SHALL have ports: funct3_0, funct3_1  input  3 each  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have ports: wdata0, wdata1  input  DATA_W each  store data, right-aligned.
REQ-010 SHALL have ports: gnt  output  2  per-port request accepted this cycle.
REQ-011 SHALL have ports: rsp_valid  output  2  one-cycle completion pulse.
REQ-012 SHALL have ports: rsp_err  output  1  completion was misaligned, qualified by rsp_valid.
REQ-013 SHALL have ports: rsp_rdata  output  DATA_W  formatted load data, qualified by rsp_valid.
REQ-014 SHALL have ports: busy  output  1  FSM not IDLE.
REQ-015 SHALL have ports: CS  output  1  DM chip select; OE  output  1  DM output enable.
REQ-016 SHALL have ports: WEB  output  4  active-low byte write enables; A  output  ADDR_W  word address.
REQ-017 SHALL have ports: DI  output  DATA_W  DM write data; DO  input  DATA_W  DM read data, valid the cycle after the read address.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, RESP, ERR.
REQ-019 SHALL, in IDLE with any req set, select one winner, assert gnt[winner] combinationally that cycle, latch winner's we/addr/funct3/wdata, and go to ACCESS (or ERR if misaligned).
REQ-020 SHALL hold gnt at 0 in every state except IDLE; requesters hold req and fields stable until gnt.
REQ-021 SHALL arbitrate round-robin: a single requester always wins; on simultaneous requests the port not granted last wins; the last-grant pointer updates on every gnt.
REQ-022 SHALL treat as misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0; funct3 011/110/111 treated as W.
REQ-023 SHALL, in ACCESS, drive CS=1, A=addr[ADDR_W+1:2], for a read OE=1 and WEB=1111, for a write OE=0.
REQ-024 SHALL, on a write in ACCESS: B -> WEB[addr[1:0]]=0, others 1, wdata[7:0] placed at bit 8*addr[1:0]; H -> WEB bits {addr[1],0}+:2 = 00, wdata[15:0] at bit 16*addr[1]; W -> WEB=0000, DI=wdata; unused DI bits 0.
REQ-025 SHALL, on a write, pulse rsp_valid[port] in the ACCESS cycle and return to IDLE (2-cycle occupancy).
REQ-026 SHALL, on a read, go ACCESS -> RESP; in RESP, CS=0 and OE=1, pulse rsp_valid[port], drive rsp_rdata from DO, return to IDLE (3-cycle occupancy).
REQ-027 SHALL format load data from the addressed lane: B sign-extend 8 bits, H sign-extend 16 bits, BU/HU zero-extend, W unmodified.
REQ-028 SHALL, in ERR, keep CS=0 and WEB=1111, pulse rsp_valid[port] with rsp_err=1 and rsp_rdata=0, then return to IDLE; DM is never touched.
REQ-029 SHALL drive CS=0, OE=0, WEB=1111, A=0, DI=0 whenever not in ACCESS, except OE=1 in RESP.
REQ-030 SHALL not accept a new request in the cycle a response pulses; next accept is the following IDLE cycle.
REQ-031 SHALL keep rsp_err=0 and rsp_rdata=0 whenever no rsp_valid bit is set.

Reset
REQ-032 SHALL, while rst=0, force IDLE, last-grant pointer = port 1 (port 0 wins the first tie), all outputs 0 except WEB=1111.
REQ-033 SHALL abort an in-flight transaction on reset with no rsp_valid; a write aborted in ACCESS keeps WEB=1111 from reset assertion onward.

Verification
REQ-034 Reset, then port0 SW addr=0x100 wdata=0xDEADBEEF -> gnt=01 at T0; T1: CS=1, A=0x040, WEB=0000, DI=0xDEADBEEF, rsp_valid=01.
REQ-035 Port0 LB addr=0x103 with DO=0x80FF_FFFF -> rsp_valid=01 two cycles after gnt, rsp_rdata=0xFFFFFF80; LBU gives 0x00000080.
REQ-036 Port1 SH addr=0x22 wdata=0x1234 -> WEB=0011, DI=0x12340000, A=0x008.
REQ-037 Both ports request reads continuously -> grants alternate 0,1,0,1 every 3 cycles, with no starvation.
REQ-038 Port0 LW addr=0x102 -> ERR: CS never 1, rsp_valid=01 with rsp_err=1 and rsp_rdata=0 one cycle after gnt.
REQ-039 rst asserted in ACCESS of a write -> WEB=1111, CS=0 immediately, no rsp_valid; after release, busy=0.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter in front of a single-ported data
// memory (DM). Port 0 is the CPU MEM stage, port 1 is the DMA engine. One
// transaction is in flight at a time; sub-word stores are lane-steered with
// byte write enables and loads are extracted from the addressed lane.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | accepting requests, grant issued combinationally
// ACCESS | DM cycle (CS=1); writes complete here, reads move to RESP
// RESP   | read data from DM presented on rsp_rdata
// ERR    | misaligned request answered with rsp_err, DM untouched
module dm_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [2:0]        funct3_0,
    input  logic [2:0]        funct3_1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              CS,
    output logic              OE,
    output logic [3:0]        WEB,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] DI,
    input  logic [DATA_W-1:0] DO
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                port_q, port_d;
    logic                we_q, we_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [2:0]          f3_q, f3_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                win;
    logic                sel_we;
    logic [ADDR_W+1:0]   sel_addr;
    logic [2:0]          sel_f3;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_mis;

    // Address bits above the DM word range are ignored.
    logic                unused_addr_hi;
    assign unused_addr_hi = ^{addr0[31:ADDR_W+2], addr1[31:ADDR_W+2]};

    // funct3[1:0] carries the size: 00 byte, 01 half, anything else word.
    logic                is_b, is_h;
    assign is_b = (f3_q[1:0] == 2'b00);
    assign is_h = (f3_q[1:0] == 2'b01);

    // Round-robin pick: lone requester wins, on a tie the port not granted last.
    always_comb begin
        win = 1'b0;
        if (req == 2'b10)
            win = 1'b1;
        else if (req == 2'b11)
            win = ~last_q;
    end

    // Mux the winner's request fields and classify its alignment.
    always_comb begin
        sel_we    = win ? we[1] : we[0];
        sel_addr  = win ? addr1[ADDR_W+1:0] : addr0[ADDR_W+1:0];
        sel_f3    = win ? funct3_1 : funct3_0;
        sel_wdata = win ? wdata1 : wdata0;
        case (sel_f3)
            3'b000, 3'b100: sel_mis = 1'b0;
            3'b001, 3'b101: sel_mis = sel_addr[0];
            default:        sel_mis = |sel_addr[1:0];
        endcase
    end

    // State, grant pointer and latched request fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic and grant; the grant is masked while reset is held.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        port_d  = port_q;
        we_d    = we_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        gnt     = 2'b00;
        case (state_q)
            IDLE: begin
                if (rst && (|req)) begin
                    gnt[win] = 1'b1;
                    last_d   = win;
                    port_d   = win;
                    we_d     = sel_we;
                    addr_d   = sel_addr;
                    f3_d     = sel_f3;
                    wdata_d  = sel_wdata;
                    state_d  = sel_mis ? ERR : ACCESS;
                end
            end
            ACCESS:  state_d = we_q ? IDLE : RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic [15:0] do_lane;
    assign do_lane = 16'(DO >> {addr_q[1:0], 3'b000});

    // DM pins and response outputs; everything parks at its idle value by default.
    always_comb begin
        CS        = 1'b0;
        OE        = 1'b0;
        WEB       = 4'hF;
        A         = '0;
        DI        = '0;
        rsp_valid = 2'b00;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        case (state_q)
            ACCESS: begin
                CS = 1'b1;
                A  = addr_q[ADDR_W+1:2];
                if (we_q) begin
                    rsp_valid[port_q] = 1'b1;
                    if (is_b) begin
                        WEB = ~(4'b0001 << addr_q[1:0]);
                        DI  = {{(DATA_W-8){1'b0}}, wdata_q[7:0]} << {addr_q[1:0], 3'b000};
                    end else if (is_h) begin
                        WEB = ~(4'b0011 << {addr_q[1], 1'b0});
                        DI  = {{(DATA_W-16){1'b0}}, wdata_q[15:0]} << {addr_q[1], 4'b0000};
                    end else begin
                        WEB = 4'b0000;
                        DI  = wdata_q;
                    end
                end else begin
                    OE = 1'b1;
                end
            end
            RESP: begin
                OE = 1'b1;
                rsp_valid[port_q] = 1'b1;
                if (is_b)
                    rsp_rdata = {{(DATA_W-8){do_lane[7] & ~f3_q[2]}}, do_lane[7:0]};
                else if (is_h)
                    rsp_rdata = {{(DATA_W-16){do_lane[15] & ~f3_q[2]}}, do_lane[15:0]};
                else
                    rsp_rdata = DO;
            end
            ERR: begin
                rsp_valid[port_q] = 1'b1;
                rsp_err           = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: stimulus pushes expected responses and DM
// accesses into queues at grant time; two monitors pop and compare on the
// falling edge whenever the DUT presents a response or a DM access.
module tb_dm_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic [1:0]        req;
    logic [1:0]        we;
    logic [31:0]       addr0, addr1;
    logic [2:0]        funct3_0, funct3_1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [1:0]        gnt;
    logic [1:0]        rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    logic              CS, OE;
    logic [3:0]        WEB;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] DI;
    logic [DATA_W-1:0] DO;
    logic [DATA_W-1:0] do_val;

    assign DO = do_val;

    dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .funct3_0(funct3_0), .funct3_1(funct3_1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy), .CS(CS), .OE(OE),
        .WEB(WEB), .A(A), .DI(DI), .DO(DO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic        err;
        logic [31:0] rdata;
        logic        chk_data;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [13:0] a;
        logic [3:0]  web;
        logic [31:0] di;
        logic        oe;
        int          cyc;
    } acc_t;

    rsp_t rsp_q[$];
    acc_t acc_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic push_rsp(input int p, input logic err, input logic [31:0] rd,
                            input logic chk_rd, input int at);
        rsp_t r;
        r.valid    = (p == 0) ? 2'b01 : 2'b10;
        r.err      = err;
        r.rdata    = err ? 32'h0 : rd;
        r.chk_data = err | chk_rd;
        r.cyc      = at;
        rsp_q.push_back(r);
    endtask

    task automatic push_acc(input logic [31:0] ad, input logic [3:0] web,
                            input logic [31:0] di, input logic oe, input int at);
        acc_t a;
        a.a   = ad[15:2];
        a.web = web;
        a.di  = di;
        a.oe  = oe;
        a.cyc = at;
        acc_q.push_back(a);
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (rst) begin
            if (rsp_valid != 2'b00) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", {30'b0, rsp_valid}, 32'h0);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("rsp_valid", {30'b0, rsp_valid}, {30'b0, r.valid});
                    chk("rsp_err", {31'b0, rsp_err}, {31'b0, r.err});
                    if (r.chk_data)
                        chk("rsp_rdata", rsp_rdata, r.rdata);
                    chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
                end
            end else begin
                chk("idle_rsp_err", {31'b0, rsp_err}, 32'h0);
                chk("idle_rsp_rdata", rsp_rdata, 32'h0);
            end
        end
    end

    // DM access monitor.
    always @(negedge clk) begin
        if (rst) begin
            if (CS) begin
                if (acc_q.size() == 0) begin
                    chk("unexpected_cs", {31'b0, CS}, 32'h0);
                end else begin
                    acc_t a;
                    a = acc_q.pop_front();
                    chk("dm_a", {18'b0, A}, {18'b0, a.a});
                    chk("dm_web", {28'b0, WEB}, {28'b0, a.web});
                    chk("dm_di", DI, a.di);
                    chk("dm_oe", {31'b0, OE}, {31'b0, a.oe});
                    chk("dm_cycle", 32'(cyc), 32'(a.cyc));
                end
            end else begin
                chk("idle_web", {28'b0, WEB}, 32'hF);
                chk("idle_di", DI, 32'h0);
            end
        end
    end

    // One transaction on port p; expectations are queued once the grant is seen.
    task automatic do_req(input int p, input logic w, input logic [31:0] ad,
                          input logic [2:0] f3, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rd,
                          input logic chk_rd, input logic [3:0] exp_web,
                          input logic [31:0] exp_di);
        int n;
        int lat;
        @(negedge clk);
        if (p == 0) begin
            addr0 = ad; funct3_0 = f3; wdata0 = wd;
        end else begin
            addr1 = ad; funct3_1 = f3; wdata1 = wd;
        end
        we[p]  = w;
        req[p] = 1'b1;
        #1;
        n = 0;
        while (!gnt[p] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("gnt", {30'b0, gnt}, (p == 0) ? 32'h1 : 32'h2);
        lat = (exp_err || w) ? 1 : 2;
        push_rsp(p, exp_err, exp_rd, chk_rd, cyc + lat);
        if (!exp_err)
            push_acc(ad, w ? exp_web : 4'hF, w ? exp_di : 32'h0, ~w, cyc + 1);
        @(posedge clk);
        #1;
        req[p] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_g;
        rst = 1'b0;
        req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; funct3_0 = '0; funct3_1 = '0;
        wdata0 = '0; wdata1 = '0; do_val = '0;

        // Reset state, with a request held to show the grant is masked.
        repeat (2) @(negedge clk);
        req = 2'b01; addr0 = 32'h100; funct3_0 = 3'b010;
        #1;
        chk("rst_gnt", {30'b0, gnt}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_cs", {31'b0, CS}, 32'h0);
        chk("rst_oe", {31'b0, OE}, 32'h0);
        chk("rst_web", {28'b0, WEB}, 32'hF);
        chk("rst_a", {18'b0, A}, 32'h0);
        chk("rst_di", DI, 32'h0);
        chk("rst_rsp_valid", {30'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        req = 2'b00;
        @(negedge clk);
        rst = 1'b1;

        // SW / LB / LBU / LH / LHU on port 0
        do_req(0, 1'b1, 32'h100, 3'b010, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 4'b0000, 32'hDEADBEEF);
        do_val = 32'h80FF_FFFF;
        do_req(0, 1'b0, 32'h103, 3'b000, 32'h0, 1'b0, 32'hFFFFFF80, 1'b1, 4'hF, 32'h0);
        do_req(0, 1'b0, 32'h103, 3'b100, 32'h0, 1'b0, 32'h00000080, 1'b1, 4'hF, 32'h0);
        do_req(0, 1'b0, 32'h102, 3'b001, 32'h0, 1'b0, 32'hFFFF80FF, 1'b1, 4'hF, 32'h0);
        do_req(0, 1'b0, 32'h102, 3'b101, 32'h0, 1'b0, 32'h000080FF, 1'b1, 4'hF, 32'h0);
        do_req(0, 1'b0, 32'h100, 3'b010, 32'h0, 1'b0, 32'h80FFFFFF, 1'b1, 4'hF, 32'h0);

        // SH on port 1 (also leaves port 1 as last granted)
        do_req(1, 1'b1, 32'h22, 3'b001, 32'h1234, 1'b0, 32'h0, 1'b0, 4'b0011, 32'h12340000);

        // Both ports reading continuously: grants 0,1,0,1 every 3 cycles
        @(negedge clk);
        addr0 = 32'h200; funct3_0 = 3'b010;
        addr1 = 32'h204; funct3_1 = 3'b010;
        we = 2'b00; do_val = 32'hCAFEF00D;
        req = 2'b11;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c % 3 == 0)
                exp_g = ((c / 3) % 2 == 1) ? 2'b10 : 2'b01;
            else
                exp_g = 2'b00;
            chk("rr_gnt", {30'b0, gnt}, {30'b0, exp_g});
            if (exp_g == 2'b01) begin
                push_rsp(0, 1'b0, 32'hCAFEF00D, 1'b1, cyc + 2);
                push_acc(32'h200, 4'hF, 32'h0, 1'b1, cyc + 1);
            end else if (exp_g == 2'b10) begin
                push_rsp(1, 1'b0, 32'hCAFEF00D, 1'b1, cyc + 2);
                push_acc(32'h204, 4'hF, 32'h0, 1'b1, cyc + 1);
            end
            if (c == 9) begin
                @(posedge clk);
                #1;
                req = 2'b00;
            end else begin
                @(negedge clk);
            end
        end
        repeat (4) @(negedge clk);

        // Misaligned requests go to ERR without touching DM
        do_req(0, 1'b0, 32'h102, 3'b010, 32'h0, 1'b1, 32'h0, 1'b1, 4'hF, 32'h0);
        do_req(1, 1'b1, 32'h101, 3'b001, 32'hFFFF, 1'b1, 32'h0, 1'b1, 4'hF, 32'h0);
        do_req(1, 1'b0, 32'h101, 3'b011, 32'h0, 1'b1, 32'h0, 1'b1, 4'hF, 32'h0);

        // SB on port 1, lane 1
        do_req(1, 1'b1, 32'h101, 3'b000, 32'h000000AB, 1'b0, 32'h0, 1'b0, 4'b1101, 32'h0000AB00);

        // Reset asserted during the ACCESS cycle of a write
        @(negedge clk);
        addr0 = 32'h300; funct3_0 = 3'b010; wdata0 = 32'h55AA55AA;
        we[0] = 1'b1; req[0] = 1'b1;
        #1;
        chk("abort_gnt", {30'b0, gnt}, 32'h1);
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        chk("abort_cs_before", {31'b0, CS}, 32'h1);
        rst = 1'b0;
        #1;
        chk("abort_web", {28'b0, WEB}, 32'hF);
        chk("abort_cs", {31'b0, CS}, 32'h0);
        chk("abort_rsp", {30'b0, rsp_valid}, 32'h0);
        @(negedge clk);
        chk("abort_rsp_later", {30'b0, rsp_valid}, 32'h0);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        repeat (3) @(negedge clk);

        chk("rsp_queue_empty", 32'(rsp_q.size()), 32'h0);
        chk("acc_queue_empty", 32'(acc_q.size()), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
